// File: rtl/spi_ide_pkg.sv
// rtl/spi_ide_pkg.sv - shared SPI-IDE frame layout and host state encoding
package spi_ide_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam int FRAME_BITS   = 24;
  localparam int CMD_BITS     = 8;
  localparam int DATA_BITS    = FRAME_BITS - CMD_BITS;
  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_ADDR_MSB = 2;
  localparam int CMD_ADDR_LSB = 0;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                 wr,
    input logic [2:0]           addr,
    input logic [DATA_BITS-1:0] wdata
  );
    logic [CMD_BITS-1:0] cmd;
    cmd                            = '0;
    cmd[CMD_WR_BIT]                = wr;
    cmd[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
    return {cmd, wdata};
  endfunction

endpackage

// File: rtl/spi_ide_clkdiv.sv
// rtl/spi_ide_clkdiv.sv - sclk half-period tick generator, counts only while enabled
module spi_ide_clkdiv #(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLKDIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_ide_host.sv
// rtl/spi_ide_host.sv - SPI-IDE bridge initiator, 24-bit mode-0 frames
// Optional irq/irq_ack completion interrupt under SPI_IDE_HOST_IRQ_EN.
module spi_ide_host
  import spi_ide_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        seln,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
`ifdef SPI_IDE_HOST_IRQ_EN
  ,
  output logic        irq,
  input  logic        irq_ack
`endif
);

  localparam logic [4:0] BIT_LAST = 5'(FRAME_BITS - 1);

  state_t                  state, state_next;
  logic [FRAME_BITS-1:0]   sr;
  logic [4:0]              bit_cnt;
  logic                    sclk_q, mosi_q, done_q, wr_q, gap_half;
  logic [15:0]             rdata_q;
  logic                    tick;
  logic                    accept, rise, fall, hold_end, gap_tick, finish;

  spi_ide_clkdiv #(.CLKDIV(CLKDIV)) u_clkdiv (
    .clk  (clk),
    .rstn (rstn),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The done cycle is already IDLE, so acceptance waits for the cycle after it.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    hold_end   = 1'b0;
    gap_tick   = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req && !done_q) begin
          accept     = 1'b1;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
            if (bit_cnt == BIT_LAST) state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          hold_end   = 1'b1;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          gap_tick = 1'b1;
          if (gap_half) begin
            finish     = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr       <= '0;
      bit_cnt  <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_q     <= 1'b0;
      gap_half <= 1'b0;
      rdata_q  <= '0;
    end else begin
      done_q <= finish;
      if (accept) begin
        sr       <= build_frame(wr, addr, wdata);
        mosi_q   <= wr;
        wr_q     <= wr;
        bit_cnt  <= '0;
        gap_half <= 1'b0;
      end
      if (rise) begin
        sclk_q <= 1'b1;
        sr     <= {sr[FRAME_BITS-2:0], miso};
      end
      // After each rise the outgoing bit has moved up into sr[23].
      if (fall) begin
        sclk_q <= 1'b0;
        if (bit_cnt != BIT_LAST) begin
          bit_cnt <= bit_cnt + 5'd1;
          mosi_q  <= sr[FRAME_BITS-1];
        end
      end
      if (hold_end) mosi_q <= 1'b0;
      if (gap_tick) gap_half <= ~gap_half;
      if (finish && !wr_q) rdata_q <= sr[15:0];
    end
  end

  assign seln  = !(state == ST_SETUP || state == ST_SHIFT || state == ST_HOLD);
  assign busy  = (state != ST_IDLE);
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign done  = done_q;
  assign rdata = rdata_q;

`ifdef SPI_IDE_HOST_IRQ_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq <= 1'b0;
    end else if (done_q) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
